// File: rtl/barrel_shifter.sv
// 8-bit logical right shifter: three cascaded rows of 2:1 muxes (shift by 1, 2, 4)
// feeding a single output register with synchronous active-high reset.

module barrel_shifter_mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  always_comb begin
    y = sel ? b : a;
  end

endmodule

module barrel_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] datain,
  input  logic [2:0] shift,
  output logic [7:0] dataout
);

  localparam int unsigned Width  = 8;
  localparam int unsigned Stages = 3;

  // stg[0] is the operand, stg[s+1] is the output of stage s.
  logic [Stages:0][Width-1:0] stg;
  logic [Width-1:0]           dataout_d;
  logic [Width-1:0]           dataout_q;

  assign stg[0] = datain;

  for (genvar s = 0; s < Stages; s++) begin : g_stage
    localparam int unsigned Dist = 1 << s;
    for (genvar i = 0; i < Width; i++) begin : g_bit
      logic hi;
      // Bits that would pull from beyond the MSB take a zero instead.
      if (i + Dist < Width) begin : g_src
        assign hi = stg[s][i+Dist];
      end else begin : g_fill
        assign hi = 1'b0;
      end

      barrel_shifter_mux2 u_mux (
        .a   (stg[s][i]),
        .b   (hi),
        .sel (shift[s]),
        .y   (stg[s+1][i])
      );
    end
  end

  always_comb begin
    dataout_d = stg[Stages];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataout_q <= '0;
    end else begin
      dataout_q <= dataout_d;
    end
  end

  assign dataout = dataout_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed self-checking bench for barrel_shifter: reset, sweep, zero fill,
// per-stage isolation, back-to-back random pairs and reset mid-stream.

module tb_barrel_shifter;

  logic       clk;
  logic       rst;
  logic [7:0] datain;
  logic [2:0] shift;
  logic [7:0] dataout;

  int total;
  int bad;

  barrel_shifter dut (
    .clk     (clk),
    .rst     (rst),
    .datain  (datain),
    .shift   (shift),
    .dataout (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] exp);
    total++;
    assert (dataout === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, dataout, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_shr(input logic [7:0] d, input logic [2:0] s);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (i + int'(s) <= 7) r[i] = d[i+int'(s)];
    end
    return r;
  endfunction

  logic [7:0] sweep_exp [8];
  logic [7:0] rd;
  logic [2:0] rs;
  logic [7:0] rexp;

  initial begin
    total = 0;
    bad   = 0;
    sweep_exp[0] = 8'b10111011;
    sweep_exp[1] = 8'b01011101;
    sweep_exp[2] = 8'b00101110;
    sweep_exp[3] = 8'b00010111;
    sweep_exp[4] = 8'b00001011;
    sweep_exp[5] = 8'b00000101;
    sweep_exp[6] = 8'b00000010;
    sweep_exp[7] = 8'b00000001;

    // Reset with all-ones input must still give zero.
    rst    = 1'b1;
    datain = 8'hFF;
    shift  = 3'd0;
    step();
    check("reset_1", 8'h00);
    step();
    check("reset_2", 8'h00);
    rst = 1'b0;
    step();
    check("post_reset", 8'hFF);

    // Full sweep, one shift amount per cycle.
    datain = 8'b10111011;
    for (int s = 0; s < 8; s++) begin
      shift = 3'(s);
      step();
      check($sformatf("sweep_%0d", s), sweep_exp[s]);
    end

    // Zero fill.
    datain = 8'hFF;
    shift  = 3'b101;
    step();
    check("fill_ff_5", 8'h07);
    datain = 8'h80;
    shift  = 3'd7;
    step();
    check("fill_80_7", 8'h01);

    // Each mux stage on its own.
    datain = 8'hA5;
    shift  = 3'd1;
    step();
    check("stage0_a5", 8'h52);
    shift = 3'd2;
    step();
    check("stage1_a5", 8'h29);
    shift = 3'd4;
    step();
    check("stage2_a5", 8'h0A);

    // Back-to-back random pairs against the bit-level model.
    for (int k = 0; k < 16; k++) begin
      rd     = 8'($urandom);
      rs     = 3'($urandom_range(0, 7));
      datain = rd;
      shift  = rs;
      rexp   = ref_shr(rd, rs);
      step();
      check($sformatf("rand_%0d", k), rexp);
    end

    // Reset mid-stream during a sweep.
    datain = 8'b10111011;
    for (int s = 0; s < 3; s++) begin
      shift = 3'(s);
      step();
      check($sformatf("mid_sweep_%0d", s), sweep_exp[s]);
    end
    // Synchronous reset must not act between edges.
    shift = 3'd3;
    rst   = 1'b1;
    #2;
    check("rst_between_edges", sweep_exp[2]);
    step();
    check("mid_reset", 8'h00);
    rst   = 1'b0;
    shift = 3'd4;
    step();
    check("mid_after_4", sweep_exp[4]);
    shift = 3'd5;
    step();
    check("mid_after_5", sweep_exp[5]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
